// File: rtl/sram_arbiter.sv
// Arbiter sharing one SRAM controller transaction port among display (0),
// camera (1) and UART (2) requesters, with timeout abort and anti-starvation.
module sram_arbiter #(
  parameter int AW           = 20,
  parameter int DW           = 32,
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req,
  input  logic [2:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [1:0]    grant_id,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RECOVER} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          rr_ptr_q, rr_ptr_d;  // 0: port 1 has round-robin priority, 1: port 2
  logic [2:0]    ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]    win_id;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= SW'(STARVE_LIMIT)) ? v : v + SW'(1);
  endfunction

  always_comb begin
    win_id    = 2'd0;
    win_we    = we[0];
    win_addr  = addr0;
    win_wdata = wdata0;
    if (req[0] && (starve_cnt_q < SW'(STARVE_LIMIT))) begin
      win_id = 2'd0;
    end else if (req[1] || req[2]) begin
      if (!rr_ptr_q) win_id = req[1] ? 2'd1 : 2'd2;
      else           win_id = req[2] ? 2'd2 : 2'd1;
    end
    case (win_id)
      2'd1: begin win_we = we[1]; win_addr = addr1; win_wdata = wdata1; end
      2'd2: begin win_we = we[2]; win_addr = addr2; win_wdata = wdata2; end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    starve_cnt_d = starve_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    ack_d        = 3'b000;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    grant_id_d   = grant_id_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req != 3'b000) begin
          grant_id_d  = win_id;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
          mem_read_d  = !win_we;
          mem_write_d = win_we;
          timer_d     = '0;
          state_d     = S_BUSY;
          if (win_id == 2'd0) begin
            starve_cnt_d = (req[2:1] != 2'b00) ? sat_inc(starve_cnt_q) : '0;
          end else begin
            starve_cnt_d = '0;
            rr_ptr_d     = (win_id == 2'd1);
          end
        end
      end
      S_BUSY: begin
        timer_d = timer_q + TW'(1);
        // A real completion wins over a timeout landing in the same cycle.
        if (mem_done) begin
          if (mem_read_q) rdata_d = mem_rdata;
          ack_d       = 3'b001 << grant_id_q;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          timer_d     = '0;
          state_d     = S_RECOVER;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          ack_d       = 3'b001 << grant_id_q;
          err_d       = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          timer_d     = '0;
          state_d     = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (!mem_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      starve_cnt_q <= '0;
      rr_ptr_q     <= 1'b0;
      ack_q        <= 3'b000;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      grant_id_q   <= 2'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      starve_cnt_q <= starve_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      grant_id_q   <= grant_id_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_id_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed requester traffic against a
// small SRAM-controller model; a monitor checks every ack against a queue.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req, tb_we;
  logic [AW-1:0] tb_addr [3];
  logic [DW-1:0] tb_wdata [3];
  logic [2:0]    ack;
  logic          err, busy, mem_read, mem_write, mem_done;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [1:0]    grant_id;
  logic [AW-1:0] mem_addr;

  typedef struct packed {
    logic [2:0]  ack;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb [$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_delay = 1;
  bit          stuck = 0;
  bit          fixed_en = 0;
  logic [31:0] fixed_val = '0;
  logic [31:0] last_rd = '0;

  sram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(tb_we),
    .addr0(tb_addr[0]), .addr1(tb_addr[1]), .addr2(tb_addr[2]),
    .wdata0(tb_wdata[0]), .wdata1(tb_wdata[1]), .wdata2(tb_wdata[2]),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic push(input logic [2:0] a, input logic e, input logic [31:0] r);
    exp_t x;
    x.ack = a; x.err = e; x.rdata = r;
    sb.push_back(x);
  endtask

  function automatic logic [31:0] rd_of(input logic [AW-1:0] a);
    return {12'hC00, a};
  endfunction

  // Controller model: done after done_delay strobe cycles, lingers one cycle.
  initial begin
    int  cnt = 0;
    bit  linger = 0;
    mem_done  = 1'b0;
    mem_rdata = 32'h0BAD0BAD;
    forever begin
      @(posedge clk);
      #1;
      if (mem_read || mem_write) begin
        cnt++;
        if (!stuck && cnt >= done_delay) begin
          mem_done = 1'b1;
          linger   = 1;
        end
      end else begin
        cnt = 0;
        if (mem_done && linger) linger = 0;
        else mem_done = 1'b0;
      end
      mem_rdata = mem_done ? (fixed_en ? fixed_val : rd_of(mem_addr)) : 32'h0BAD0BAD;
    end
  end

  // Monitor: every ack/err presentation is matched against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (ack !== 3'b000 || err !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {ack, err}, 4'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_vec", ack, e.ack);
        chk("ack_err", err, e.err);
        chk("ack_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic run_one(input int p, input logic w, input int budget, output int hi);
    bit got = 0;
    hi = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        hi++;
        if (hi == 1) begin
          chk("grant_id", grant_id, p);
          chk("strobe_kind", {mem_write, mem_read}, w ? 2'b10 : 2'b01);
          chk("mem_addr", mem_addr, tb_addr[p]);
          if (w) chk("mem_wdata", mem_wdata, tb_wdata[p]);
        end
      end
      if (ack[p]) begin
        got = 1;
        chk("strobe_low_at_ack", {mem_write, mem_read}, 2'b00);
      end
    end
    if (!got) fail_now("ack_wait");
    req[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    if (!idle) fail_now("idle_wait");
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (ack !== 3'b000) got++;
    end
    if (got < n) fail_now("ack_count_wait");
  endtask

  initial begin
    int hi;
    int ord [10];
    rst = 1'b0; req = 3'b000; tb_we = 3'b000;
    for (int i = 0; i < 3; i++) begin tb_addr[i] = '0; tb_wdata[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {ack, err, busy, mem_read, mem_write, grant_id}, 9'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", mem_addr, 20'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single read on port 0, done after 3 strobe cycles
    tb_addr[0] = 20'h00010; fixed_val = 32'hDEADBEEF; fixed_en = 1; done_delay = 3;
    push(3'b001, 1'b0, 32'hDEADBEEF); last_rd = 32'hDEADBEEF;
    req = 3'b001;
    run_one(0, 1'b0, 50, hi);
    chk("read_strobe_cycles", hi, 3);
    @(negedge clk); chk("busy_ack_plus1", busy, 1'b1);
    @(negedge clk); chk("busy_ack_plus2", busy, 1'b0);
    fixed_en = 0;

    // Contention: all three hold requests
    tb_addr[0] = 20'h00100; tb_addr[1] = 20'h00200; tb_addr[2] = 20'h00300;
    done_delay = 1;
    ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    foreach (ord[i]) push(3'b001 << ord[i], 1'b0, rd_of(tb_addr[ord[i]]));
    last_rd = rd_of(tb_addr[2]);
    req = 3'b111;
    wait_acks(10, 400);
    req = 3'b000;
    wait_idle();

    // Round robin between the low-priority ports
    ord = '{1, 2, 1, 2, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) push(3'b001 << ord[i], 1'b0, rd_of(tb_addr[ord[i]]));
    req = 3'b110;
    wait_acks(4, 200);
    req = 3'b000;
    wait_idle();

    // Single write on port 1; rdata keeps the last read
    tb_we = 3'b010; tb_addr[1] = 20'hFFFFF; tb_wdata[1] = 32'h12345678; done_delay = 2;
    push(3'b010, 1'b0, last_rd);
    req = 3'b010;
    run_one(1, 1'b1, 50, hi);
    chk("write_strobe_cycles", hi, 2);
    tb_we = 3'b000;
    wait_idle();

    // Timeout with mem_done stuck low, then a normal read
    stuck = 1; tb_addr[0] = 20'h00055;
    push(3'b001, 1'b1, last_rd);
    req = 3'b001;
    run_one(0, 1'b0, 200, hi);
    chk("timeout_cycles", hi, 64);
    wait_idle();
    stuck = 0; done_delay = 2; tb_addr[0] = 20'h00ABC;
    push(3'b001, 1'b0, rd_of(20'h00ABC)); last_rd = rd_of(20'h00ABC);
    req = 3'b001;
    run_one(0, 1'b0, 50, hi);
    chk("post_timeout_cycles", hi, 2);
    wait_idle();

    // Reset mid-BUSY, then a fresh issue of the still-pending request
    stuck = 1;
    req = 3'b001;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (mem_read) seen = 1;
      end
      if (!seen) fail_now("busy_wait");
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_strobe", {mem_read, mem_write}, 2'b00);
    chk("midrst_ack", ack, 3'b000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rdata", rdata, 32'h0);
    stuck = 0; done_delay = 2;
    @(negedge clk);
    rst = 1'b1;
    push(3'b001, 1'b0, rd_of(20'h00ABC));
    run_one(0, 1'b0, 50, hi);
    chk("post_reset_cycles", hi, 2);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external-SRAM transaction port (the read/write/workdone interface of the SRAM controller) among three requesters:
  - port 0: display/VGA frame reader
  - port 1: camera frame writer
  - port 2: UART dump/loader
- Serialises their transactions and holds downstream strobes until the controller reports completion.
- Adds a timeout guard and anti-starvation for the low-priority ports.
- Sits between the camera/VGA/UART logic and the SRAM controller in the top level. Replaces the test-pattern driver on that port.

Parameters:
- AW, 20, SRAM word-address width
- DW, 32, SRAM data width
- TIMEOUT, 64, cycles in BUSY without mem_done before abort (≥2)
- STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 or 2 is waiting

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  3  per-port request level, bit i = port i
- we  in  3  per-port write enable (1 = write, 0 = read); sampled with req
- addr0, addr1, addr2  in  AW each  per-port word address
- wdata0, wdata1, wdata2  in  DW each  per-port write data
- ack  out  3  one-cycle completion pulse, bit i = port i
- err  out  1  one-cycle pulse coincident with ack when the transaction timed out
- rdata  out  DW  read data of last completed read; held until next completed read
- busy  out  1  high whenever state ≠ IDLE
- grant_id  out  2  port currently/last granted (debug)
- mem_read  out  1  read strobe to SRAM controller
- mem_write  out  1  write strobe to SRAM controller
- mem_addr  out  AW  address to SRAM controller
- mem_wdata  out  DW  write data to SRAM controller
- mem_done  in  1  controller completion level (workdone)
- mem_rdata  in  DW  controller read data, valid while mem_done=1

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, state IDLE, rr_ptr=port 1, starve_cnt=0, timer=0. Takes effect mid-transaction: strobes drop next edge, no ack issued.
- State machine: IDLE → BUSY → RECOVER → IDLE.
- IDLE:
  - If req≠0, select winner, latch its addr/wdata/we into mem_addr/mem_wdata, set grant_id.
  - Assert mem_read (we=0) or mem_write (we=1), registered, from the next cycle. Go BUSY. timer=0.
- Arbitration, evaluated in IDLE only:
  - If req[0]=1 and starve_cnt<STARVE_LIMIT: grant port 0.
  - Else, if req[1]|req[2], grant by round robin: rr_ptr port first if requesting, else the other. rr_ptr flips to the non-granted low port after each low-port grant.
  - Else, if req[0]: grant port 0.
  - starve_cnt: +1 on each port-0 grant while req[1]|req[2]=1; clears on any low-port grant or when req[2:1]=0 at grant time; saturates at STARVE_LIMIT.
- BUSY:
  - Strobe and latched address/data held stable.
  - timer increments each cycle.
  - If mem_done=1: rdata←mem_rdata (reads only); ack[grant_id] pulses next cycle; strobes drop; go RECOVER.
  - Else, if timer=TIMEOUT-1: ack[grant_id] and err pulse; rdata unchanged; strobes drop; go RECOVER.
- RECOVER:
  - Stay until mem_done=0; minimum 1 cycle.
  - Then IDLE; no new issue in the same cycle.
- Latency:
  - Request seen in IDLE at cycle N gives mem strobe high at N+1.
  - Completion with mem_done first seen high at cycle M gives ack high at M+1 and strobe low at M+1.
  - Minimum back-to-back issue spacing: 3 cycles (BUSY ≥1, RECOVER ≥1, IDLE 1).
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - Drop req in the cycle after ack, or keep it high to queue another transaction.
  - Changes to a non-granted port's inputs are harmless.
- Simultaneous events:
  - mem_done and timeout in the same cycle: treated as a normal completion, err=0.
  - req changes during BUSY/RECOVER: ignored until IDLE.
  - ack is never multi-hot.
- Width/wrap:
  - timer is ⌈log2 TIMEOUT⌉+1 bits and never wraps.
  - starve_cnt saturates and never wraps.

Test Plan:
- Single read: req=001, addr0=0x00010, controller returns done after 3 cycles with 0xDEADBEEF → mem_read high 3 cycles, ack=001 one cycle, rdata=0xDEADBEEF, err=0, busy falls 2 cycles after ack.
- Single write: req=010, we=010, addr1=0xFFFFF, wdata1=0x12345678 → mem_write with mem_addr=0xFFFFF and mem_wdata=0x12345678 until done; ack=010; rdata unchanged.
- Contention: req=111 held, controller done in 1 cycle → grant order 0,0,0,0,1,0,0,0,0,2 (STARVE_LIMIT=4) and never two ack bits set.
- Round robin: req=110 held → grants alternate 1,2,1,2.
- Timeout: req=001, mem_done stuck 0 → ack=001 and err=1 exactly TIMEOUT cycles after strobe rise; strobe drops; next request serviced normally.
- Reset mid-BUSY: assert rst=0 during BUSY → next edge mem_read=0, ack=000, busy=0. After release, a pending req is issued fresh.
